// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_pkg                                                         |
// | Brief    : Active-low glyph constants and scan FSM encodings.               |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package seg7_pkg;

    // Segment order {a,b,c,d,e,f,g}, 0 = segment lit
    localparam logic [6:0] GLYPH_0   = 7'b0000001;
    localparam logic [6:0] GLYPH_1   = 7'b1001111;
    localparam logic [6:0] GLYPH_2   = 7'b0010010;
    localparam logic [6:0] GLYPH_3   = 7'b0000110;
    localparam logic [6:0] GLYPH_4   = 7'b1001100;
    localparam logic [6:0] GLYPH_5   = 7'b0100100;
    localparam logic [6:0] GLYPH_6   = 7'b0100000;
    localparam logic [6:0] GLYPH_7   = 7'b0001111;
    localparam logic [6:0] GLYPH_8   = 7'b0000000;
    localparam logic [6:0] GLYPH_9   = 7'b0000100;
    localparam logic [6:0] GLYPH_OFF = 7'b1111111;

    localparam logic [0:0] ST_SHOW = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_decode                                                      |
// | Brief    : BCD to active-low seven-segment glyph; non-BCD codes blank.      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = GLYPH_OFF;
        case (bcd)
            4'd0:    seg_n = GLYPH_0;
            4'd1:    seg_n = GLYPH_1;
            4'd2:    seg_n = GLYPH_2;
            4'd3:    seg_n = GLYPH_3;
            4'd4:    seg_n = GLYPH_4;
            4'd5:    seg_n = GLYPH_5;
            4'd6:    seg_n = GLYPH_6;
            4'd7:    seg_n = GLYPH_7;
            4'd8:    seg_n = GLYPH_8;
            4'd9:    seg_n = GLYPH_9;
            default: seg_n = GLYPH_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan_ctrl                                                   |
// | Brief    : Double-buffered N-digit seven-segment scanner with blanking.     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_GAP   = 2
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lz_blank,
    output logic                    ready,
    output logic [N_DIGITS-1:0]     an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_tick
);

    localparam int c_cnt_w = $clog2(max3(REFRESH_DIV, BLANK_GAP, 2));
    localparam int c_idx_w = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [c_cnt_w-1:0]  c_show_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0]  c_gap_last  = c_cnt_w'((BLANK_GAP > 0) ? BLANK_GAP - 1 : 0);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] c_an_one    = N_DIGITS'(1);

    logic [0:0]            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_idx_w-1:0]    r_idx;
    logic [4*N_DIGITS-1:0] r_act_bcd;
    logic [N_DIGITS-1:0]   r_act_dp;
    logic [4*N_DIGITS-1:0] r_pend_bcd;
    logic [N_DIGITS-1:0]   r_pend_dp;
    logic                  r_valid;

    logic [0:0]            w_state_nx;
    logic [c_cnt_w-1:0]    w_cnt_nx;
    logic [c_idx_w-1:0]    w_idx_nx;
    logic [c_idx_w-1:0]    w_idx_inc;
    logic                  w_slot_end;
    logic                  w_boundary;
    logic                  w_take;
    logic                  w_xfer;
    logic                  w_valid_nx;
    logic [4*N_DIGITS-1:0] w_act_bcd_nx;
    logic [N_DIGITS-1:0]   w_act_dp_nx;
    logic [N_DIGITS-1:0]   w_zero_above;
    logic                  w_zero_acc;
    logic [3:0]            w_nibble;
    logic [6:0]            w_glyph;
    logic                  w_blank;

    // Scan sequencing: SHOW for REFRESH_DIV cycles, then an optional GAP
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_idx_nx   = r_idx;
        w_slot_end = 1'b0;
        w_idx_inc  = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        case (r_state)
            ST_SHOW: begin
                if (r_cnt == c_show_last) begin
                    w_cnt_nx = '0;
                    if (BLANK_GAP == 0) begin
                        w_idx_nx   = w_idx_inc;
                        w_slot_end = 1'b1;
                    end else begin
                        w_state_nx = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_SHOW;
                    w_idx_nx   = w_idx_inc;
                    w_slot_end = 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_SHOW;
                w_cnt_nx   = '0;
            end
        endcase
        w_boundary = w_slot_end && (r_idx == c_idx_last);
    end

    // take and xfer are exclusive: ready is always the inverse of r_valid
    always_comb begin
        w_take       = load && ready;
        w_xfer       = w_boundary && r_valid;
        w_act_bcd_nx = w_xfer ? r_pend_bcd : r_act_bcd;
        w_act_dp_nx  = w_xfer ? r_pend_dp  : r_act_dp;
        w_valid_nx   = w_take ? 1'b1 : (w_xfer ? 1'b0 : r_valid);
    end

    always_comb begin
        w_zero_acc   = 1'b1;
        w_zero_above = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_zero_acc      = w_zero_acc && (w_act_bcd_nx[4*i +: 4] == 4'd0);
            w_zero_above[i] = w_zero_acc;
        end
        w_nibble = w_act_bcd_nx[{w_idx_nx, 2'b00} +: 4];
        w_blank  = lz_blank && (w_idx_nx != '0) && w_zero_above[w_idx_nx];
    end

    seg7_decode u_decode (
        .bcd   (w_nibble),
        .seg_n (w_glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SHOW;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_act_bcd  <= '0;
            r_act_dp   <= '0;
            r_pend_bcd <= '0;
            r_pend_dp  <= '0;
            r_valid    <= 1'b0;
            ready      <= 1'b1;
            an_n       <= '1;
            seg_n      <= GLYPH_OFF;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_idx      <= w_idx_nx;
            r_act_bcd  <= w_act_bcd_nx;
            r_act_dp   <= w_act_dp_nx;
            r_valid    <= w_valid_nx;
            ready      <= !w_valid_nx;
            frame_tick <= w_boundary;
            if (w_take) begin
                r_pend_bcd <= bcd_in;
                r_pend_dp  <= dp_in;
            end
            // Digit content is latched only on SHOW entry (all anodes off
            // while in SHOW only happens on the first cycle after reset).
            if (w_state_nx == ST_GAP) begin
                an_n  <= '1;
                seg_n <= GLYPH_OFF;
                dp_n  <= 1'b1;
            end else if (w_slot_end || (an_n == '1)) begin
                an_n  <= ~(c_an_one << w_idx_nx);
                seg_n <= w_blank ? GLYPH_OFF : w_glyph;
                dp_n  <= ~w_act_dp_nx[w_idx_nx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seg7_scan_ctrl                                                |
// | Brief    : Directed self-checking bench for seg7_scan_ctrl (4 digits).      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int BG = 1;

    localparam logic [6:0] G0   = 7'b0000001;
    localparam logic [6:0] G1   = 7'b1001111;
    localparam logic [6:0] G2   = 7'b0010010;
    localparam logic [6:0] G3   = 7'b0000110;
    localparam logic [6:0] G4   = 7'b1001100;
    localparam logic [6:0] G5   = 7'b0100100;
    localparam logic [6:0] G6   = 7'b0100000;
    localparam logic [6:0] G7   = 7'b0001111;
    localparam logic [6:0] G8   = 7'b0000000;
    localparam logic [6:0] GOFF = 7'b1111111;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic          lz_blank;
    logic          ready;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic          frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_ctrl #(
        .N_DIGITS    (N),
        .REFRESH_DIV (RD),
        .BLANK_GAP   (BG)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .ready      (ready),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_off(input string tag);
        check({tag, "_an"},    an_n,       4'hF);
        check({tag, "_seg"},   seg_n,      GOFF);
        check({tag, "_dp"},    dp_n,       1'b1);
        check({tag, "_ready"}, ready,      1'b1);
        check({tag, "_tick"},  frame_tick, 1'b0);
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = frame_tick;
        end
        check("frame_tick_seen", seen, 1'b1);
    endtask

    // Called at the negedge where frame_tick is high; ends on digit 3's gap
    task automatic check_frame(input string tag, input logic [27:0] seg_exp, input logic [3:0] dpn_exp);
        logic [3:0] an_exp;
        for (int d = 0; d < N; d++) begin
            an_exp = ~(4'b0001 << d);
            check($sformatf("%s_d%0d_an",  tag, d), an_n,  an_exp);
            check($sformatf("%s_d%0d_seg", tag, d), seg_n, seg_exp[7*d +: 7]);
            check($sformatf("%s_d%0d_dp",  tag, d), dp_n,  dpn_exp[d]);
            repeat (RD) @(negedge clk);
            check($sformatf("%s_d%0d_gap_an",  tag, d), an_n,  4'hF);
            check($sformatf("%s_d%0d_gap_seg", tag, d), seg_n, GOFF);
            check($sformatf("%s_d%0d_gap_tick", tag, d), frame_tick, 1'b0);
            if (d < N - 1) @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] dp, input logic lz);
        wait_tick();
        check("ready_pre_load", ready, 1'b1);
        lz_blank = lz;
        bcd_in   = b;
        dp_in    = dp;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("ready_post_load", ready, 1'b0);
        wait_tick();
        check("ready_after_xfer", ready, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        lz_blank = 1'b0;
        bcd_in   = '0;
        dp_in    = '0;

        repeat (2) @(negedge clk);
        check_off("por");
        rst_n = 1'b1;
        @(negedge clk);
        check("release_an",  an_n,  4'b1110);
        check("release_seg", seg_n, G0);

        // Asynchronous reset in the middle of digit 0's SHOW slot
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_off("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerelease_an",  an_n,  4'b1110);
        check("rerelease_seg", seg_n, G0);
        check("rerelease_dp",  dp_n,  1'b1);

        do_load(16'h1234, 4'b0010, 1'b0);
        check("tick_1234", frame_tick, 1'b1);
        check_frame("f1234", {G1, G2, G3, G4}, 4'b1101);

        do_load(16'h0007, 4'b0100, 1'b1);
        check_frame("lz0007", {GOFF, GOFF, GOFF, G7}, 4'b1011);
        do_load(16'h0000, 4'b0000, 1'b1);
        check_frame("lz0000", {GOFF, GOFF, GOFF, G0}, 4'b1111);

        // Second load while pending is full must be dropped
        wait_tick();
        lz_blank = 1'b0;
        bcd_in   = 16'h1111;
        dp_in    = 4'b0000;
        load     = 1'b1;
        @(negedge clk);
        bcd_in = 16'h9999;
        check("ready_busy", ready, 1'b0);
        @(negedge clk);
        load = 1'b0;
        wait_tick();
        check_frame("keep1111_a", {G1, G1, G1, G1}, 4'b1111);
        wait_tick();
        check_frame("keep1111_b", {G1, G1, G1, G1}, 4'b1111);

        do_load(16'h00A5, 4'b0000, 1'b0);
        check_frame("f00a5", {G0, G0, GOFF, G5}, 4'b1111);

        // Load landing exactly on the boundary edge
        do_load(16'h1234, 4'b0010, 1'b0);
        check_frame("pre_bnd", {G1, G2, G3, G4}, 4'b1101);
        bcd_in = 16'h5678;
        dp_in  = 4'b0000;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("bnd_tick",  frame_tick, 1'b1);
        check("bnd_ready", ready,      1'b0);
        check_frame("hold1234", {G1, G2, G3, G4}, 4'b1101);
        wait_tick();
        check("ready_5678", ready, 1'b1);
        check_frame("f5678", {G5, G6, G7, G8}, 4'b1111);

        // Reset mid-frame clears the active buffer
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_off("async_rst2");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_an",  an_n,  4'b1110);
        check("rst2_seg", seg_n, G0);
        check("rst2_dp",  dp_n,  1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode seven-segment display on the Spartan-7 board. It accepts a packed BCD word through a ready/load handshake and double-buffers it so a frame never tears. It then cycles the shared anode lines digit by digit, routing each nibble through one seven-segment decoder. Optional leading-zero blanking and a dead-time gap between digits are included to suppress ghosting.

## Interface
- N_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 100000, clk cycles each digit is lit (>=1)
- BLANK_GAP, 2, clk cycles all anodes are off between digits (>=0)

- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- load  input  1  capture request for bcd_in/dp_in, honoured only when ready=1
- bcd_in  input  4*N_DIGITS  packed BCD; nibble i is digit i, digit 0 rightmost
- dp_in  input  N_DIGITS  decimal point per digit, 1 = lit
- lz_blank  input  1  1 = blank leading zeros (level, sampled live)
- ready  output  1  1 = pending buffer empty, load accepted
- an_n  output  N_DIGITS  anode enables, active-low, one-hot-low or all-high
- seg_n  output  7  segments {a,b,c,d,e,f,g}, active-low
- dp_n  output  1  decimal point, active-low
- frame_tick  output  1  one-cycle pulse at each frame boundary

## Operation
- Two buffers: pending (bcd, dp, valid) and active (bcd, dp).
- load && ready: pending <= inputs, valid <= 1, ready drops next cycle. load && !ready: ignored, no state change.
- Frame boundary = final cycle of digit N_DIGITS-1's slot: last GAP cycle, or last SHOW cycle if BLANK_GAP=0. At this edge, if valid was already 1 before the cycle: active <= pending, valid <= 0, ready rises next cycle. A load coincident with the boundary lands in pending and transfers at the next boundary.
- FSM states:
  - SHOW: an_n has bit idx low; seg_n/dp_n decode active nibble idx. Lasts REFRESH_DIV cycles.
  - GAP: an_n all 1, seg_n all 1, dp_n 1. Lasts BLANK_GAP cycles, skipped if 0.
  - Transitions: SHOW -> GAP (or directly to SHOW of next idx if BLANK_GAP=0); GAP -> SHOW with idx+1, wrapping N_DIGITS-1 -> 0.
- Decode is active-low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Codes 10..15 give 1111111.
- Leading-zero blank: when lz_blank=1 and idx!=0 and active nibbles idx..N_DIGITS-1 are all 0, then seg_n=1111111 and dp_n follows dp. The anode is still driven. Digit 0 is never blanked.
- Reset, including mid-frame: state SHOW, idx 0, counter 0, active and pending cleared to 0, valid 0, ready 1, an_n all 1, seg_n 1111111, dp_n 1, frame_tick 0. The first SHOW begins on the first cycle after rst_n deasserts.

## Timing
- All outputs registered; they change on the same edge as the state/idx update.
- Cycle counter width: $clog2(max(REFRESH_DIV, BLANK_GAP, 2)); counts 0..limit-1, then reloads 0.
- Frame period: N_DIGITS*(REFRESH_DIV+BLANK_GAP) cycles.
- Load-to-display latency: at most one frame plus one cycle.
- frame_tick is high during the cycle after the boundary edge, coincident with digit 0 SHOW of the new frame.
- lz_blank and dp_in changes take effect on the next SHOW entry. dp_in affects only captured data.

## Structure
- Shared package/header seg7_pkg: the 7-bit active-low glyph constants (GLYPH_0..GLYPH_9, GLYPH_OFF) and the state encodings (ST_SHOW, ST_GAP).
- One combinational sub-module seg7_decode (4-bit BCD in, 7-bit active-low out, GLYPH_OFF for codes >9), instantiated once and fed by the idx-selected nibble.
- Everything else (FSM, counter, buffers, blanking mask) stays in seg7_scan_ctrl.

## Test plan
Bench parameters: N_DIGITS=4, REFRESH_DIV=4, BLANK_GAP=1.
- Reset asserted mid-SHOW -> an_n=1111, seg_n=1111111, dp_n=1, ready=1, frame_tick=0 immediately; after release, digit 0 shows 0000001 with an_n=1110.
- load with bcd_in=16'h1234, dp_in=4'b0010 -> ready=0; after the boundary, frame_tick pulses:
  - digit 0: an_n=1110, seg_n=1001100, dp_n=1 for 4 cycles; then 1 cycle an_n=1111.
  - digit 1: an_n=1101, seg_n=0000110, dp_n=0; then ready=1.
- lz_blank=1, load 16'h0007 -> digits 3..1 show seg_n=1111111 with their anodes low; digit 0 shows 0001111. Load 16'h0000 -> digit 0 shows 0000001.
- Second load while ready=0 (16'h9999 after 16'h1111) -> ignored; display stays 1111 after the boundary.
- load 16'h00A5 -> digit 1 shows 1111111, digit 0 shows 0100100.
- Load asserted exactly on the boundary cycle, with the display at 16'h1234 and new value 16'h5678 -> the old value is kept for that frame; 16'h5678 appears one frame later.
